// File: rtl/sys_cmd_ctrl.sv
// sys_cmd_ctrl
// UART command controller. Decodes byte-serial command frames from the RX
// datapath and drives register-file and ALU strobes. Read data and ALU results
// are streamed to the TX FIFO least-significant frame first, and the stream
// stalls while the FIFO is full.
//
// Ports:
//   CLK, RST                 clock, asynchronous active-low reset
//   RX_P_DATA/RX_P_VLD       received frame and its one-cycle strobe
//   RdData/RdData_Valid      register-file read response
//   ALU_OUT/OUT_VALID        ALU result
//   FIFO_FULL                TX FIFO back-pressure
//   ALU_FUNC/ALU_EN/CLK_EN   ALU function, start strobe, clock-gate enable
//   RF_ADDR/WrEn/RdEn/WrData register-file access
//   TX_P_DATA/TX_P_VLD       frame pushed into the TX FIFO
//   clk_div_en               clock-divider enable (high once out of reset)
//   BUSY                     high while a command is in progress
//   ERR                      one-cycle watchdog-abort pulse
//
// Build option: define SYS_CMD_TIMEOUT_EN to add a response watchdog of
// RSP_TIMEOUT cycles in RD_WAIT/ALU_WAIT. Without it ERR is tied low.
//
// state    | meaning
// ---------+------------------------------------------------
// IDLE     | waiting for a command frame
// WR_ADDR  | register write, waiting for the address frame
// WR_DATA  | register write, waiting for the data frame
// RD_ADDR  | register read, waiting for the address frame
// RD_WAIT  | waiting for RdData_Valid
// OP_A     | waiting for operand A (written to address 0)
// OP_B     | waiting for operand B (written to address 1)
// ALU_FN   | waiting for the ALU function frame
// ALU_WAIT | waiting for OUT_VALID
// TX_SEND  | pushing response frames into the TX FIFO
module sys_cmd_ctrl #(
  parameter int FRAME_WIDTH    = 8,
  parameter int ALU_DATA_WIDTH = 16,
  parameter int ALU_FUNC_WIDTH = 4,
  parameter int RF_ADDR_WIDTH  = 4,
  parameter int RSP_TIMEOUT    = 255
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [FRAME_WIDTH-1:0]    RX_P_DATA,
  input  logic                      RX_P_VLD,
  input  logic [FRAME_WIDTH-1:0]    RdData,
  input  logic                      RdData_Valid,
  input  logic [ALU_DATA_WIDTH-1:0] ALU_OUT,
  input  logic                      OUT_VALID,
  input  logic                      FIFO_FULL,
  output logic [ALU_FUNC_WIDTH-1:0] ALU_FUNC,
  output logic                      ALU_EN,
  output logic                      CLK_EN,
  output logic [RF_ADDR_WIDTH-1:0]  RF_ADDR,
  output logic                      WrEn,
  output logic                      RdEn,
  output logic [FRAME_WIDTH-1:0]    WrData,
  output logic [FRAME_WIDTH-1:0]    TX_P_DATA,
  output logic                      TX_P_VLD,
  output logic                      clk_div_en,
  output logic                      BUSY,
  output logic                      ERR
);

  localparam int NFR   = ALU_DATA_WIDTH / FRAME_WIDTH;
  localparam int IDX_W = (NFR > 1) ? $clog2(NFR) : 1;
  localparam logic [IDX_W-1:0] LAST_ALU = IDX_W'(NFR - 1);
  localparam logic [FRAME_WIDTH-1:0] CMD_WR  = FRAME_WIDTH'(8'hAA);
  localparam logic [FRAME_WIDTH-1:0] CMD_RD  = FRAME_WIDTH'(8'hBB);
  localparam logic [FRAME_WIDTH-1:0] CMD_OPS = FRAME_WIDTH'(8'hCC);
  localparam logic [FRAME_WIDTH-1:0] CMD_FN  = FRAME_WIDTH'(8'hDD);

  if (((ALU_DATA_WIDTH % FRAME_WIDTH) != 0) || (RSP_TIMEOUT < 1)) begin : g_bad_cfg
    $error("sys_cmd_ctrl: invalid parameter combination");
  end

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_WR_ADDR  = 4'd1,
    S_WR_DATA  = 4'd2,
    S_RD_ADDR  = 4'd3,
    S_RD_WAIT  = 4'd4,
    S_OP_A     = 4'd5,
    S_OP_B     = 4'd6,
    S_ALU_FN   = 4'd7,
    S_ALU_WAIT = 4'd8,
    S_TX_SEND  = 4'd9
  } state_t;

  state_t                     state_q, state_d;
  logic [RF_ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [ALU_DATA_WIDTH-1:0]  rsp_q, rsp_d;
  logic [IDX_W-1:0]           idx_q, idx_d, last_q, last_d;
  logic                       wr_en_q, wr_en_d, rd_en_q, rd_en_d, alu_en_q, alu_en_d;
  logic                       tx_vld_q, tx_vld_d, clk_en_q, clk_en_d, busy_q, div_en_q;
  logic [RF_ADDR_WIDTH-1:0]   rf_addr_q, rf_addr_d;
  logic [FRAME_WIDTH-1:0]     wr_data_q, wr_data_d, tx_data_q, tx_data_d;
  logic [ALU_FUNC_WIDTH-1:0]  alu_func_q, alu_func_d;
  logic                       rsp_done;
  logic [ALU_DATA_WIDTH-1:0]  rsp_val;
  logic [IDX_W-1:0]           rsp_last;
  logic                       tmo_hit;

`ifdef SYS_CMD_TIMEOUT_EN
  localparam int TO_W = $clog2(RSP_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LOAD = TO_W'(RSP_TIMEOUT - 1);
  logic [TO_W-1:0] tmo_q, tmo_d;
  logic            err_q, err_d, wait_st;

  // Down-counter reloads whenever outside a wait state; the two wait states
  // are never adjacent, so each wait starts from a fresh count.
  assign wait_st = (state_q == S_RD_WAIT) || (state_q == S_ALU_WAIT);
  assign tmo_hit = wait_st && (tmo_q == '0);

  always_comb begin
    tmo_d = TO_LOAD;
    if (wait_st && (tmo_q != '0)) tmo_d = tmo_q - 1'b1;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end

  assign ERR = err_q;
`else
  assign tmo_hit = 1'b0;
  assign ERR     = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rsp_d      = rsp_q;
    idx_d      = idx_q;
    last_d     = last_q;
    wr_en_d    = 1'b0;
    rd_en_d    = 1'b0;
    alu_en_d   = 1'b0;
    tx_vld_d   = 1'b0;
    rf_addr_d  = '0;
    wr_data_d  = '0;
    alu_func_d = '0;
    tx_data_d  = '0;
    rsp_done   = 1'b0;
    rsp_val    = '0;
    rsp_last   = '0;
`ifdef SYS_CMD_TIMEOUT_EN
    err_d      = 1'b0;
`endif
    case (state_q)
      S_IDLE: if (RX_P_VLD) begin
        if (RX_P_DATA == CMD_WR)       state_d = S_WR_ADDR;
        else if (RX_P_DATA == CMD_RD)  state_d = S_RD_ADDR;
        else if (RX_P_DATA == CMD_OPS) state_d = S_OP_A;
        else if (RX_P_DATA == CMD_FN)  state_d = S_ALU_FN;
      end
      S_WR_ADDR: if (RX_P_VLD) begin
        addr_d  = RX_P_DATA[RF_ADDR_WIDTH-1:0];
        state_d = S_WR_DATA;
      end
      S_WR_DATA: if (RX_P_VLD) begin
        wr_en_d   = 1'b1;
        rf_addr_d = addr_q;
        wr_data_d = RX_P_DATA;
        state_d   = S_IDLE;
      end
      S_RD_ADDR: if (RX_P_VLD) begin
        rd_en_d   = 1'b1;
        rf_addr_d = RX_P_DATA[RF_ADDR_WIDTH-1:0];
        state_d   = S_RD_WAIT;
      end
      S_OP_A: if (RX_P_VLD) begin
        wr_en_d   = 1'b1;
        rf_addr_d = '0;
        wr_data_d = RX_P_DATA;
        state_d   = S_OP_B;
      end
      S_OP_B: if (RX_P_VLD) begin
        wr_en_d   = 1'b1;
        rf_addr_d = RF_ADDR_WIDTH'(1);
        wr_data_d = RX_P_DATA;
        state_d   = S_ALU_FN;
      end
      S_ALU_FN: if (RX_P_VLD) begin
        alu_en_d   = 1'b1;
        alu_func_d = RX_P_DATA[ALU_FUNC_WIDTH-1:0];
        state_d    = S_ALU_WAIT;
      end
      // A valid is ignored while its own request strobe is still high.
      S_RD_WAIT: begin
        if (RdData_Valid && !rd_en_q) begin
          rsp_done = 1'b1;
          rsp_val  = ALU_DATA_WIDTH'(RdData);
          rsp_last = '0;
        end else if (tmo_hit) begin
          state_d = S_IDLE;
`ifdef SYS_CMD_TIMEOUT_EN
          err_d   = 1'b1;
`endif
        end
      end
      S_ALU_WAIT: begin
        if (OUT_VALID && !alu_en_q) begin
          rsp_done = 1'b1;
          rsp_val  = ALU_OUT;
          rsp_last = LAST_ALU;
        end else if (tmo_hit) begin
          state_d = S_IDLE;
`ifdef SYS_CMD_TIMEOUT_EN
          err_d   = 1'b1;
`endif
        end
      end
      S_TX_SEND: if (!FIFO_FULL) begin
        tx_vld_d  = 1'b1;
        tx_data_d = rsp_q[FRAME_WIDTH-1:0];
        rsp_d     = rsp_q >> FRAME_WIDTH;
        if (idx_q == last_q) begin
          idx_d   = '0;
          state_d = S_IDLE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // The first frame goes out in the capture cycle so TX_P_VLD follows the
    // response valid by exactly one cycle when the FIFO has room.
    if (rsp_done) begin
      last_d = rsp_last;
      if (!FIFO_FULL) begin
        tx_vld_d  = 1'b1;
        tx_data_d = rsp_val[FRAME_WIDTH-1:0];
        rsp_d     = rsp_val >> FRAME_WIDTH;
        if (rsp_last == '0) begin
          idx_d   = '0;
          state_d = S_IDLE;
        end else begin
          idx_d   = IDX_W'(1);
          state_d = S_TX_SEND;
        end
      end else begin
        rsp_d   = rsp_val;
        idx_d   = '0;
        state_d = S_TX_SEND;
      end
    end

    clk_en_d = (state_d == S_OP_A) || (state_d == S_OP_B) ||
               (state_d == S_ALU_FN) || (state_d == S_ALU_WAIT);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      rsp_q      <= '0;
      idx_q      <= '0;
      last_q     <= '0;
      wr_en_q    <= 1'b0;
      rd_en_q    <= 1'b0;
      alu_en_q   <= 1'b0;
      tx_vld_q   <= 1'b0;
      clk_en_q   <= 1'b0;
      busy_q     <= 1'b0;
      div_en_q   <= 1'b0;
      rf_addr_q  <= '0;
      wr_data_q  <= '0;
      alu_func_q <= '0;
      tx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rsp_q      <= rsp_d;
      idx_q      <= idx_d;
      last_q     <= last_d;
      wr_en_q    <= wr_en_d;
      rd_en_q    <= rd_en_d;
      alu_en_q   <= alu_en_d;
      tx_vld_q   <= tx_vld_d;
      clk_en_q   <= clk_en_d;
      busy_q     <= (state_d != S_IDLE);
      div_en_q   <= 1'b1;
      rf_addr_q  <= rf_addr_d;
      wr_data_q  <= wr_data_d;
      alu_func_q <= alu_func_d;
      tx_data_q  <= tx_data_d;
    end
  end

  assign ALU_FUNC   = alu_func_q;
  assign ALU_EN     = alu_en_q;
  assign CLK_EN     = clk_en_q;
  assign RF_ADDR    = rf_addr_q;
  assign WrEn       = wr_en_q;
  assign RdEn       = rd_en_q;
  assign WrData     = wr_data_q;
  assign TX_P_DATA  = tx_data_q;
  assign TX_P_VLD   = tx_vld_q;
  assign clk_div_en = div_en_q;
  assign BUSY       = busy_q;

endmodule

// File: tb/tb_sys_cmd_ctrl.sv
module tb_sys_cmd_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic [7:0]  RX_P_DATA;
  logic        RX_P_VLD;
  logic [7:0]  RdData;
  logic        RdData_Valid;
  logic [15:0] ALU_OUT;
  logic        OUT_VALID;
  logic        FIFO_FULL;
  logic [3:0]  ALU_FUNC;
  logic        ALU_EN;
  logic        CLK_EN;
  logic [3:0]  RF_ADDR;
  logic        WrEn;
  logic        RdEn;
  logic [7:0]  WrData;
  logic [7:0]  TX_P_DATA;
  logic        TX_P_VLD;
  logic        clk_div_en;
  logic        BUSY;
  logic        ERR;

  int errors = 0;
  int checks = 0;

  sys_cmd_ctrl #(
    .FRAME_WIDTH(8), .ALU_DATA_WIDTH(16), .ALU_FUNC_WIDTH(4),
    .RF_ADDR_WIDTH(4), .RSP_TIMEOUT(10)
  ) dut (
    .CLK(CLK), .RST(RST),
    .RX_P_DATA(RX_P_DATA), .RX_P_VLD(RX_P_VLD),
    .RdData(RdData), .RdData_Valid(RdData_Valid),
    .ALU_OUT(ALU_OUT), .OUT_VALID(OUT_VALID), .FIFO_FULL(FIFO_FULL),
    .ALU_FUNC(ALU_FUNC), .ALU_EN(ALU_EN), .CLK_EN(CLK_EN),
    .RF_ADDR(RF_ADDR), .WrEn(WrEn), .RdEn(RdEn), .WrData(WrData),
    .TX_P_DATA(TX_P_DATA), .TX_P_VLD(TX_P_VLD),
    .clk_div_en(clk_div_en), .BUSY(BUSY), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  // Advance one cycle; outputs are then observed 1 time unit after the edge.
  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d);
    RX_P_DATA = d;
    RX_P_VLD  = 1'b1;
    tick();
    RX_P_VLD  = 1'b0;
    RX_P_DATA = 8'h00;
  endtask

  task automatic test_reset;
    RST = 1'b0;
    RX_P_DATA = 8'h00; RX_P_VLD = 1'b0; RdData = 8'h00; RdData_Valid = 1'b0;
    ALU_OUT = 16'h0000; OUT_VALID = 1'b0; FIFO_FULL = 1'b0;
    tick(); tick();
    checks++;
    if ({ALU_FUNC, ALU_EN, CLK_EN, RF_ADDR, WrEn, RdEn, WrData, TX_P_DATA,
         TX_P_VLD, clk_div_en, BUSY, ERR} !== 36'h0) begin
      errors++;
      $display("FAIL reset_outputs got busy=%0b div=%0b wren=%0b txv=%0b exp all 0",
               BUSY, clk_div_en, WrEn, TX_P_VLD);
    end
    RST = 1'b1;
    tick();
    checks++;
    if (clk_div_en !== 1'b1) begin
      errors++; $display("FAIL clk_div_en got=%0b exp=1", clk_div_en);
    end
  endtask

  task automatic test_write;
    send_frame(8'hAA);
    checks++;
    if (BUSY !== 1'b1) begin errors++; $display("FAIL wr_busy got=%0b exp=1", BUSY); end
    send_frame(8'h05);
    send_frame(8'h3C);
    checks++;
    if ({WrEn, RF_ADDR, WrData} !== {1'b1, 4'h5, 8'h3C}) begin
      errors++;
      $display("FAIL wr_strobe got wren=%0b addr=%h data=%h exp 1/5/3c", WrEn, RF_ADDR, WrData);
    end
    tick();
    checks++;
    if ({WrEn, RF_ADDR, WrData, BUSY} !== 14'h0) begin
      errors++;
      $display("FAIL wr_after got wren=%0b addr=%h data=%h busy=%0b exp all 0",
               WrEn, RF_ADDR, WrData, BUSY);
    end
  endtask

  task automatic test_read;
    send_frame(8'hBB);
    send_frame(8'h07);
    checks++;
    if ({RdEn, RF_ADDR} !== {1'b1, 4'h7}) begin
      errors++; $display("FAIL rd_strobe got rden=%0b addr=%h exp 1/7", RdEn, RF_ADDR);
    end
    // valid during the RdEn cycle must be ignored
    RdData = 8'h99; RdData_Valid = 1'b1;
    tick();
    RdData_Valid = 1'b0;
    checks++;
    if ({RdEn, RF_ADDR, TX_P_VLD} !== 6'h0) begin
      errors++;
      $display("FAIL rd_ignore got rden=%0b addr=%h txv=%0b exp 0/0/0", RdEn, RF_ADDR, TX_P_VLD);
    end
    RdData = 8'h5A; RdData_Valid = 1'b1;
    tick();
    RdData_Valid = 1'b0;
    checks++;
    if ({TX_P_VLD, TX_P_DATA} !== {1'b1, 8'h5A}) begin
      errors++; $display("FAIL rd_tx got txv=%0b data=%h exp 1/5a", TX_P_VLD, TX_P_DATA);
    end
    tick();
    checks++;
    if ({TX_P_VLD, BUSY} !== 2'b00) begin
      errors++; $display("FAIL rd_done got txv=%0b busy=%0b exp 0/0", TX_P_VLD, BUSY);
    end
  endtask

  task automatic test_alu_ops;
    send_frame(8'hCC);
    checks++;
    if (CLK_EN !== 1'b1) begin errors++; $display("FAIL ops_clken got=%0b exp=1", CLK_EN); end
    send_frame(8'h12);
    checks++;
    if ({WrEn, RF_ADDR, WrData, CLK_EN} !== {1'b1, 4'h0, 8'h12, 1'b1}) begin
      errors++;
      $display("FAIL ops_a got wren=%0b addr=%h data=%h clken=%0b exp 1/0/12/1",
               WrEn, RF_ADDR, WrData, CLK_EN);
    end
    send_frame(8'h34);
    checks++;
    if ({WrEn, RF_ADDR, WrData} !== {1'b1, 4'h1, 8'h34}) begin
      errors++;
      $display("FAIL ops_b got wren=%0b addr=%h data=%h exp 1/1/34", WrEn, RF_ADDR, WrData);
    end
    send_frame(8'h00);
    checks++;
    if ({ALU_EN, ALU_FUNC, WrEn, CLK_EN} !== {1'b1, 4'h0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL ops_fn got aluen=%0b func=%h wren=%0b clken=%0b exp 1/0/0/1",
               ALU_EN, ALU_FUNC, WrEn, CLK_EN);
    end
    tick();
    ALU_OUT = 16'h0046; OUT_VALID = 1'b1;
    checks++;
    if ({ALU_EN, CLK_EN} !== 2'b01) begin
      errors++; $display("FAIL ops_wait got aluen=%0b clken=%0b exp 0/1", ALU_EN, CLK_EN);
    end
    tick();
    OUT_VALID = 1'b0;
    checks++;
    if ({TX_P_VLD, TX_P_DATA, CLK_EN} !== {1'b1, 8'h46, 1'b0}) begin
      errors++;
      $display("FAIL ops_tx0 got txv=%0b data=%h clken=%0b exp 1/46/0", TX_P_VLD, TX_P_DATA, CLK_EN);
    end
    tick();
    checks++;
    if ({TX_P_VLD, TX_P_DATA} !== {1'b1, 8'h00}) begin
      errors++; $display("FAIL ops_tx1 got txv=%0b data=%h exp 1/00", TX_P_VLD, TX_P_DATA);
    end
    tick();
    checks++;
    if ({TX_P_VLD, BUSY} !== 2'b00) begin
      errors++; $display("FAIL ops_done got txv=%0b busy=%0b exp 0/0", TX_P_VLD, BUSY);
    end
  endtask

  task automatic test_fifo_full;
    send_frame(8'hDD);
    send_frame(8'h02);
    checks++;
    if ({ALU_EN, ALU_FUNC} !== {1'b1, 4'h2}) begin
      errors++; $display("FAIL ff_fn got aluen=%0b func=%h exp 1/2", ALU_EN, ALU_FUNC);
    end
    FIFO_FULL = 1'b1;
    tick();
    ALU_OUT = 16'hABCD; OUT_VALID = 1'b1;
    tick();
    OUT_VALID = 1'b0;
    checks++;
    if (TX_P_VLD !== 1'b0) begin errors++; $display("FAIL ff_stall0 got txv=%0b exp=0", TX_P_VLD); end
    tick();
    FIFO_FULL = 1'b0;
    checks++;
    if (TX_P_VLD !== 1'b0) begin errors++; $display("FAIL ff_stall1 got txv=%0b exp=0", TX_P_VLD); end
    tick();
    checks++;
    if ({TX_P_VLD, TX_P_DATA} !== {1'b1, 8'hCD}) begin
      errors++; $display("FAIL ff_tx0 got txv=%0b data=%h exp 1/cd", TX_P_VLD, TX_P_DATA);
    end
    tick();
    checks++;
    if ({TX_P_VLD, TX_P_DATA} !== {1'b1, 8'hAB}) begin
      errors++; $display("FAIL ff_tx1 got txv=%0b data=%h exp 1/ab", TX_P_VLD, TX_P_DATA);
    end
    tick();
    checks++;
    if ({TX_P_VLD, BUSY} !== 2'b00) begin
      errors++; $display("FAIL ff_done got txv=%0b busy=%0b exp 0/0", TX_P_VLD, BUSY);
    end
  endtask

  task automatic test_ignore_and_reset;
    send_frame(8'h77);
    checks++;
    if (BUSY !== 1'b0) begin errors++; $display("FAIL ign_busy got=%0b exp=0", BUSY); end
    send_frame(8'hAA);
    checks++;
    if (BUSY !== 1'b1) begin errors++; $display("FAIL ign_wraddr got busy=%0b exp=1", BUSY); end
    send_frame(8'h09);
    RST = 1'b0;
    #1;
    checks++;
    if ({ALU_FUNC, ALU_EN, CLK_EN, RF_ADDR, WrEn, RdEn, WrData, TX_P_DATA,
         TX_P_VLD, clk_div_en, BUSY, ERR} !== 36'h0) begin
      errors++;
      $display("FAIL midreset got busy=%0b div=%0b wren=%0b exp all 0", BUSY, clk_div_en, WrEn);
    end
    tick();
    RST = 1'b1;
    tick();
    send_frame(8'h3C);
    checks++;
    if ({WrEn, BUSY} !== 2'b00) begin
      errors++; $display("FAIL post_reset got wren=%0b busy=%0b exp 0/0", WrEn, BUSY);
    end
  endtask

`ifdef SYS_CMD_TIMEOUT_EN
  task automatic test_timeout;
    send_frame(8'hBB);
    send_frame(8'h01);
    for (int i = 1; i <= 9; i++) begin
      checks++;
      if ({ERR, TX_P_VLD, BUSY} !== 3'b001) begin
        errors++;
        $display("FAIL to_wait cyc=%0d got err=%0b txv=%0b busy=%0b exp 0/0/1", i, ERR, TX_P_VLD, BUSY);
      end
      tick();
    end
    tick();
    checks++;
    if ({ERR, TX_P_VLD, BUSY} !== 3'b100) begin
      errors++;
      $display("FAIL to_err got err=%0b txv=%0b busy=%0b exp 1/0/0", ERR, TX_P_VLD, BUSY);
    end
    tick();
    checks++;
    if ({ERR, TX_P_VLD} !== 2'b00) begin
      errors++; $display("FAIL to_after got err=%0b txv=%0b exp 0/0", ERR, TX_P_VLD);
    end
    // valid in the expiry cycle wins over the watchdog
    send_frame(8'hBB);
    send_frame(8'h01);
    for (int i = 1; i <= 9; i++) tick();
    RdData = 8'h3E; RdData_Valid = 1'b1;
    tick();
    RdData_Valid = 1'b0;
    checks++;
    if ({ERR, TX_P_VLD, TX_P_DATA} !== {1'b0, 1'b1, 8'h3E}) begin
      errors++;
      $display("FAIL to_race got err=%0b txv=%0b data=%h exp 0/1/3e", ERR, TX_P_VLD, TX_P_DATA);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_write();
    test_read();
    test_alu_ops();
    test_fifo_full();
    test_ignore_and_reset();
`ifdef SYS_CMD_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
